// File: rtl/uart_rx_deserializer.sv
// UART receive front end: synchronises rx, finds the start edge, samples each bit
// at mid-bit on the oversampling tick and hands the captured frame fields to the checker.
module uart_rx_deserializer #(
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  input  logic                 sample_tick,
  input  logic [1:0]           parity_type,
  output logic [DATA_BITS-1:0] data,
  output logic                 start_bit,
  output logic                 stop_bit,
  output logic                 parity_bit,
  output logic [1:0]           parity_type_o,
  output logic                 recieved_flag,
  output logic                 busy
);

  localparam int CW = $clog2(OVERSAMPLE);
  localparam int IW = $clog2(DATA_BITS + 1);

  localparam logic [CW-1:0] HALF_LAST = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] FULL_LAST = CW'(OVERSAMPLE - 1);
  localparam logic [IW-1:0] LAST_IDX  = IW'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t state, state_next;

  logic                 rx_meta, rx_s;
  logic [CW-1:0]        tick_cnt;
  logic [IW-1:0]        bit_idx;
  logic [DATA_BITS-1:0] shift;
  logic [1:0]           ptype_frame;
  logic                 start_cap;
  logic                 parity_cap;
  logic                 frame_has_parity;

  logic cnt_clr, cnt_inc;
  logic frame_start, take_start, take_data, take_parity, take_stop;

  // NOTE: both flops reset to the idle line level so reset release never looks like a start edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  assign frame_has_parity = (ptype_frame == 2'b01) || (ptype_frame == 2'b10);
  assign busy             = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // NOTE: every output of this block gets a default first, otherwise a latch is inferred.
  always_comb begin
    state_next  = state;
    cnt_clr     = 1'b0;
    cnt_inc     = 1'b0;
    frame_start = 1'b0;
    take_start  = 1'b0;
    take_data   = 1'b0;
    take_parity = 1'b0;
    take_stop   = 1'b0;

    if (sample_tick) begin
      case (state)
        IDLE: begin
          if (!rx_s) begin
            frame_start = 1'b1;
            cnt_clr     = 1'b1;
            state_next  = START;
          end
        end
        START: begin
          if (tick_cnt == HALF_LAST) begin
            take_start = 1'b1;
            cnt_clr    = 1'b1;
            state_next = DATA;
          end else begin
            cnt_inc = 1'b1;
          end
        end
        DATA: begin
          if (tick_cnt == FULL_LAST) begin
            take_data = 1'b1;
            cnt_clr   = 1'b1;
            if (bit_idx == LAST_IDX) state_next = frame_has_parity ? PARITY : STOP;
          end else begin
            cnt_inc = 1'b1;
          end
        end
        PARITY: begin
          if (tick_cnt == FULL_LAST) begin
            take_parity = 1'b1;
            cnt_clr     = 1'b1;
            state_next  = STOP;
          end else begin
            cnt_inc = 1'b1;
          end
        end
        STOP: begin
          if (tick_cnt == FULL_LAST) begin
            take_stop  = 1'b1;
            cnt_clr    = 1'b1;
            state_next = IDLE;
          end else begin
            cnt_inc = 1'b1;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick_cnt      <= '0;
      bit_idx       <= '0;
      shift         <= '0;
      ptype_frame   <= 2'b00;
      start_cap     <= 1'b0;
      parity_cap    <= 1'b0;
      data          <= '0;
      start_bit     <= 1'b0;
      stop_bit      <= 1'b1;
      parity_bit    <= 1'b0;
      parity_type_o <= 2'b00;
      recieved_flag <= 1'b0;
    end else begin
      recieved_flag <= take_stop;

      if (cnt_clr)      tick_cnt <= '0;
      else if (cnt_inc) tick_cnt <= tick_cnt + CW'(1);

      if (frame_start) begin
        ptype_frame <= parity_type;
        bit_idx     <= '0;
      end

      if (take_start) start_cap <= rx_s;

      // LSB arrives first, so shifting in from the top leaves it at bit 0 after DATA_BITS shifts.
      if (take_data) begin
        shift   <= {rx_s, shift[DATA_BITS-1:1]};
        bit_idx <= (bit_idx == LAST_IDX) ? '0 : bit_idx + IW'(1);
      end

      if (take_parity) parity_cap <= rx_s;

      if (take_stop) begin
        stop_bit      <= rx_s;
        data          <= shift;
        start_bit     <= start_cap;
        parity_bit    <= frame_has_parity ? parity_cap : 1'b0;
        parity_type_o <= ptype_frame;
      end
    end
  end

endmodule

// File: doc/uart_rx_deserializer.md
Name: uart_rx_deserializer

Overview:
- UART receive front end. Synchronises the serial rx line and detects frame start.
- Samples each bit at mid-bit using a 16x oversampling tick, then presents the captured fields to the downstream error checker: data, start_bit, stop_bit, parity_bit and parity_type.
- Produces the one-cycle recieved_flag that qualifies those fields.
- Sits directly upstream of the receiver error checker, between the baud generator and the checker.

Parameters:
- OVERSAMPLE, 16, sample_tick pulses per bit period; must be even and at least 4.
- DATA_BITS, 8, data bits per frame, sent LSB first.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous active-high reset
- rx  input  1  serial line, idle high, asynchronous to clk
- sample_tick  input  1  one-clk pulse at OVERSAMPLE x baud rate
- parity_type  input  2  00/11 = no parity bit, 01 = odd, 10 = even
- data  output  DATA_BITS  captured data byte
- start_bit  output  1  rx value sampled at mid-start
- stop_bit  output  1  rx value sampled at mid-stop
- parity_bit  output  1  rx value sampled at mid-parity; 0 when no parity bit is in the frame
- parity_type_o  output  2  parity_type latched for this frame; drives the checker's parity_type
- recieved_flag  output  1  one-clk pulse, fields valid
- busy  output  1  high while the state is not IDLE

Behaviour:
- Reset values (asynchronous, while rst=1):
  - data=0, start_bit=0, stop_bit=1, parity_bit=0, parity_type_o=00, recieved_flag=0, busy=0.
  - State=IDLE, tick counter=0, bit index=0.
  - Both synchroniser flops=1.
- Synchroniser: rx passes through 2 flops (rx_s). All decisions use rx_s, so there are 2 clk of latency.
- All state and counter updates occur only on clk edges where sample_tick=1. recieved_flag is the only exception; it is cleared on the next clk regardless of tick.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - On a tick with rx_s=0, go to START.
  - Clear the counter and latch parity_type into a frame register.
  - Later changes to the parity_type input are ignored until the next frame.
- START:
  - On the (OVERSAMPLE/2)th tick after the detection tick, capture start_bit=rx_s.
  - Clear the counter and go to DATA.
  - The frame continues even if start_bit=1; the checker reports that case.
- DATA:
  - Every OVERSAMPLE ticks, shift rx_s into bit[index], LSB first, and increment index.
  - After DATA_BITS bits, go to PARITY if the latched type is 01 or 10, else go to STOP.
  - data is updated only at the end of the frame; the shift register is internal.
- PARITY: after OVERSAMPLE ticks, capture parity_bit and go to STOP.
- STOP:
  - After OVERSAMPLE ticks, capture stop_bit=rx_s.
  - Update data, parity_bit (0 if no parity bit), start_bit and parity_type_o together.
  - Pulse recieved_flag for exactly 1 clk and return to IDLE in the same cycle.
- Output timing:
  - Outputs hold their values until the next recieved_flag.
  - recieved_flag fires even when stop_bit=0; framing errors are the checker's job.
- Frame timing:
  - Flag tick = detection tick + OVERSAMPLE/2 + OVERSAMPLE*(DATA_BITS+1+P), where P=1 if the frame has a parity bit.
  - With defaults this is 152 ticks without parity and 168 ticks with parity.
- Back-to-back frames: since IDLE is re-entered at mid-stop, a new start edge arriving up to half a bit later is detected. No idle gap is required beyond the stop bit.
- Counters:
  - Tick counter is $clog2(OVERSAMPLE) bits and wraps only via explicit clear.
  - Bit index is $clog2(DATA_BITS+1) bits.
- Reset mid-frame: everything returns to reset values immediately, and no flag is produced for the partial frame.
- sample_tick held high every clk is legal; the block then behaves as if clk = 16x baud.

Test Plan:
- Defaults, parity_type=00, send 0xA5 with start 0 and stop 1 -> data=8'hA5, start_bit=0, stop_bit=1, parity_bit=0; recieved_flag high for 1 clk at tick 152 after detection; busy low afterwards.
- parity_type=01, send 0x3C with parity bit 1 -> data=8'h3C, parity_bit=1, parity_type_o=01, flag at tick 168. Changing parity_type to 10 mid-frame leaves parity_type_o=01.
- Framing error: 0x55 with stop bit 0 -> flag still pulses once, stop_bit=0, data=8'h55.
- Back-to-back: 0x01 then 0xFE, with the second start edge at the end of the first stop bit -> two flags, 160 ticks apart, data 01 then FE; no missed or extra flag.
- Assert rst for 3 clk during the DATA bit index 4 -> busy=0, outputs at reset values, no flag. A following 0x7E frame is received correctly.
- sample_tick tied high, rx held at 1 for 1000 clk -> state stays IDLE, no flag, busy=0.
